// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the pipelined restoring divider.
//   DIV_DIVIDENDLEN / DIV_DIVISORLEN / DIV_TAGW : operand and tag widths that
//                                                 size the stage record
//   datapath_len()                              : remainder datapath width
//   stage_t                                     : contents of one pipe register
//   rem_view_t                                  : {hi, lo} view of the remainder
// -----------------------------------------------------------------------------
package divider_pkg;

    localparam int DIV_DIVIDENDLEN = 16;
    localparam int DIV_DIVISORLEN  = 8;
    localparam int DIV_TAGW        = 4;

    // The partial remainder must hold the divisor shifted by up to
    // DIVIDENDLEN-1 places, hence the combined width minus one.
    function automatic int datapath_len(input int dividend_len, input int divisor_len);
        return dividend_len + divisor_len - 1;
    endfunction

    localparam int DIV_DATAPATHLEN = datapath_len(DIV_DIVIDENDLEN, DIV_DIVISORLEN);

    typedef struct packed {
        logic                       valid;
        logic [DIV_DATAPATHLEN-1:0] rem;
        logic [DIV_DIVISORLEN-1:0]  divisor;
        logic [DIV_DIVIDENDLEN-1:0] quot;
        logic [DIV_TAGW-1:0]        tag;
        logic                       dbz;
        logic                       q_neg;
        logic                       r_neg;
    } stage_t;

    // Once all steps are done the remainder is below the divisor, so only
    // the low DIVISORLEN bits carry information.
    typedef union packed {
        logic [DIV_DATAPATHLEN-1:0] raw;
        struct packed {
            logic [DIV_DATAPATHLEN-DIV_DIVISORLEN-1:0] hi;
            logic [DIV_DIVISORLEN-1:0]                 lo;
        } part;
    } rem_view_t;

endpackage

// File: rtl/div_stage.sv
// -----------------------------------------------------------------------------
// div_stage
// One combinational restoring-division step producing quotient bit SHIFT.
//   stage_in  : stage record entering the step
//   stage_out : same record with quot[SHIFT] set and rem updated
// -----------------------------------------------------------------------------
module div_stage
    import divider_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  stage_t stage_in,
    output stage_t stage_out
);

    logic [DIV_DATAPATHLEN:0] shifted_divisor;
    logic [DIV_DATAPATHLEN:0] trial;
    logic                     borrow;

    always_comb begin
        shifted_divisor = {{(DIV_DATAPATHLEN + 1 - DIV_DIVISORLEN){1'b0}}, stage_in.divisor} << SHIFT;
        // One extra bit on the left turns the sign of the difference into the borrow.
        trial  = {1'b0, stage_in.rem} - shifted_divisor;
        borrow = trial[DIV_DATAPATHLEN];

        stage_out              = stage_in;
        stage_out.quot[SHIFT]  = ~borrow;
        if (!borrow) begin
            stage_out.rem = trial[DIV_DATAPATHLEN-1:0];
        end
    end

endmodule

// File: rtl/pipelined_divider_stream.sv
// -----------------------------------------------------------------------------
// pipelined_divider_stream
// Fully pipelined restoring divider, one quotient bit per stage (MSB first),
// one operation per clock, valid/ready on both sides, tag pass-through and
// divide-by-zero flag. A zero divisor yields quotient all-ones and remainder
// equal to the low dividend bits, straight out of the datapath.
//
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   in_valid / in_ready              : input handshake
//   in_dividend, in_divisor, in_tag  : operands and opaque tag
//   out_valid / out_ready            : output handshake
//   out_quotient, out_remainder      : results
//   out_tag, out_dbz                 : tag of the result, divisor-was-zero flag
//
// Build option: SIGNED_DIV_EN -- two's complement operands; magnitudes are
// divided and signs re-applied at the output (quotient toward zero,
// remainder takes the dividend sign). Latency is identical in both builds.
//
// The stage record widths come from divider_pkg; the parameters here must
// keep their package defaults.
// -----------------------------------------------------------------------------
module pipelined_divider_stream
    import divider_pkg::*;
#(
    parameter int DIVIDENDLEN = DIV_DIVIDENDLEN,
    parameter int DIVISORLEN  = DIV_DIVISORLEN,
    parameter int TAGW        = DIV_TAGW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIVIDENDLEN-1:0] in_dividend,
    input  logic [DIVISORLEN-1:0]  in_divisor,
    input  logic [TAGW-1:0]        in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIVIDENDLEN-1:0] out_quotient,
    output logic [DIVISORLEN-1:0]  out_remainder,
    output logic [TAGW-1:0]        out_tag,
    output logic                   out_dbz
);

    stage_t entry;
    stage_t stage_reg  [DIVIDENDLEN];
    stage_t stage_next [DIVIDENDLEN];
    stage_t last;
    logic   advance;

    logic [DIVIDENDLEN-1:0] dividend_mag;
    logic [DIVISORLEN-1:0]  divisor_mag;
    logic                   dividend_neg;
    logic                   divisor_neg;

    assign last     = stage_reg[DIVIDENDLEN-1];
    // The whole pipe moves as one; it only stalls when a finished result
    // is sitting at the output and nobody takes it.
    assign advance  = !last.valid || out_ready;
    assign in_ready = advance;

`ifdef SIGNED_DIV_EN
    assign dividend_neg = in_dividend[DIVIDENDLEN-1];
    assign divisor_neg  = in_divisor[DIVISORLEN-1];
    // The most-negative value negates to itself, which is its correct
    // unsigned magnitude.
    assign dividend_mag = dividend_neg ? -in_dividend : in_dividend;
    assign divisor_mag  = divisor_neg  ? -in_divisor  : in_divisor;
`else
    assign dividend_neg = 1'b0;
    assign divisor_neg  = 1'b0;
    assign dividend_mag = in_dividend;
    assign divisor_mag  = in_divisor;
`endif

    always_comb begin
        entry                        = '0;
        entry.valid                  = in_valid && advance;
        entry.rem[DIVIDENDLEN-1:0]   = dividend_mag;
        entry.divisor                = divisor_mag;
        entry.tag                    = in_tag;
        entry.dbz                    = (in_divisor == '0);
        // Divide by zero returns raw magnitudes with no sign fix-up.
        entry.q_neg                  = !entry.dbz && (dividend_neg ^ divisor_neg);
        entry.r_neg                  = !entry.dbz && dividend_neg;
    end

    for (genvar gi = 0; gi < DIVIDENDLEN; gi++) begin : g_stage
        stage_t stage_src;
        if (gi == 0) begin : g_first
            assign stage_src = entry;
        end else begin : g_rest
            assign stage_src = stage_reg[gi-1];
        end
        div_stage #(
            .SHIFT(DIVIDENDLEN - 1 - gi)
        ) u_step (
            .stage_in (stage_src),
            .stage_out(stage_next[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIVIDENDLEN; i++) begin
                stage_reg[i] <= '0;
            end
        end else if (advance) begin
            for (int i = 0; i < DIVIDENDLEN; i++) begin
                stage_reg[i] <= stage_next[i];
            end
        end
    end

    rem_view_t rem_view;
    assign rem_view = last.rem;

    assign out_valid = last.valid;
    assign out_tag   = last.tag;
    assign out_dbz   = last.dbz;

`ifdef SIGNED_DIV_EN
    assign out_quotient  = last.q_neg ? -last.quot : last.quot;
    assign out_remainder = last.r_neg ? -rem_view.part.lo : rem_view.part.lo;
`else
    assign out_quotient  = last.quot;
    assign out_remainder = rem_view.part.lo;
`endif

endmodule

// File: tb/tb_pipelined_divider_stream.sv
module tb_pipelined_divider_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_dividend;
    logic [7:0]  in_divisor;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_quotient;
    logic [7:0]  out_remainder;
    logic [3:0]  out_tag;
    logic        out_dbz;

    int vectors     = 0;
    int miscompares = 0;

    pipelined_divider_stream dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_remainder(out_remainder),
        .out_tag      (out_tag),
        .out_dbz      (out_dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one operation (out_ready assumed high) and wait for its result.
    task automatic do_op(input logic [15:0] dd, input logic [7:0] dv, input logic [3:0] tg,
                         output logic [15:0] q, output logic [7:0] r, output logic [3:0] t,
                         output logic z, output int lat);
        @(negedge clk);
        in_valid    = 1'b1;
        in_dividend = dd;
        in_divisor  = dv;
        in_tag      = tg;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        q = out_quotient;
        r = out_remainder;
        t = out_tag;
        z = out_dbz;
        $display("op %h/%h tag %0d -> q=%h r=%h tag=%0d dbz=%b latency=%0d", dd, dv, tg, q, r, t, z, lat);
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_tag      = '0;
        out_ready   = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        vectors++;
        if (out_quotient !== 16'h0 || out_remainder !== 8'h0 || out_tag !== 4'h0 || out_dbz !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got q=%h r=%h tag=%h dbz=%b expected all 0", out_quotient, out_remainder, out_tag, out_dbz);
        end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_single();
        logic [15:0] q; logic [7:0] r; logic [3:0] t; logic z; int lat;
        do_op(16'd100, 8'd7, 4'd3, q, r, t, z, lat);
        vectors++;
        if (lat !== 16) begin miscompares++; $display("FAIL single_latency: got %0d expected 16", lat); end
        vectors++;
        if (q !== 16'd14 || r !== 8'd2 || t !== 4'd3 || z !== 1'b0) begin
            miscompares++;
            $display("FAIL single_result: got q=%0d r=%0d tag=%0d dbz=%b expected q=14 r=2 tag=3 dbz=0", q, r, t, z);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] dd [4] = '{16'd1000, 16'd65535, 16'd7, 16'd0};
        logic [7:0]  dv [4] = '{8'd10, 8'd255, 8'd9, 8'd5};
        logic [15:0] eq [4] = '{16'd100, 16'd257, 16'd0, 16'd0};
        logic [7:0]  er [4] = '{8'd0, 8'd0, 8'd7, 8'd0};
        int cyc;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            in_dividend = dd[i];
            in_divisor  = dv[i];
            in_tag      = 4'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        vectors++;
        if (cyc >= 40) begin miscompares++; $display("FAIL b2b_timeout: no result within 40 cycles"); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_quotient !== eq[i] || out_remainder !== er[i] || out_tag !== 4'(i)) begin
                miscompares++;
                $display("FAIL b2b_result%0d: got v=%b q=%0d r=%0d tag=%0d expected v=1 q=%0d r=%0d tag=%0d",
                         i, out_valid, out_quotient, out_remainder, out_tag, eq[i], er[i], i);
            end
            $display("b2b result %0d: q=%0d r=%0d tag=%0d", i, out_quotient, out_remainder, out_tag);
            @(negedge clk);
        end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_extra: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_stall();
        logic [15:0] eq [16];
        logic [7:0]  er [16];
        for (int i = 0; i < 16; i++) begin
            eq[i] = 16'((1000 + 37 * i) / (3 + i));
            er[i] = 8'((1000 + 37 * i) % (3 + i));
        end
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_fill_ready%0d: got %b expected 1", i, in_ready); end
            in_valid    = 1'b1;
            in_dividend = 16'(1000 + 37 * i);
            in_divisor  = 8'(3 + i);
            in_tag      = 4'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_quotient !== eq[0] || out_remainder !== er[0] || out_tag !== 4'd0) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got rdy=%b v=%b q=%0d r=%0d tag=%0d expected rdy=0 v=1 q=%0d r=%0d tag=0",
                         s, in_ready, out_valid, out_quotient, out_remainder, out_tag, eq[0], er[0]);
            end
            $display("stall cycle %0d: in_ready=%b q=%0d", s, in_ready, out_quotient);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_quotient !== eq[j] || out_remainder !== er[j] || out_tag !== 4'(j)) begin
                miscompares++;
                $display("FAIL stall_drain%0d: got v=%b q=%0d r=%0d tag=%0d expected v=1 q=%0d r=%0d tag=%0d",
                         j, out_valid, out_quotient, out_remainder, out_tag, eq[j], er[j], j);
            end
            $display("drain result %0d: q=%0d r=%0d tag=%0d", j, out_quotient, out_remainder, out_tag);
            @(negedge clk);
        end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_duplicate: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_dbz();
        logic [15:0] q; logic [7:0] r; logic [3:0] t; logic z; int lat;
        do_op(16'h1234, 8'h00, 4'd5, q, r, t, z, lat);
        vectors++;
        if (q !== 16'hFFFF || r !== 8'h34 || t !== 4'd5 || z !== 1'b1 || lat !== 16) begin
            miscompares++;
            $display("FAIL dbz: got q=%h r=%h tag=%0d dbz=%b lat=%0d expected q=ffff r=34 tag=5 dbz=1 lat=16", q, r, t, z, lat);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] q; logic [7:0] r; logic [3:0] t; logic z; int lat;
        int seen;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            in_dividend = 16'(500 + i);
            in_divisor  = 8'd3;
            in_tag      = 4'(i);
        end
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL areset_pre_valid: got %b expected 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_quotient !== 16'h0 || out_remainder !== 8'h0 || out_tag !== 4'h0) begin
            miscompares++;
            $display("FAIL areset_async: got v=%b q=%h r=%h tag=%h expected all 0", out_valid, out_quotient, out_remainder, out_tag);
        end
        $display("async reset asserted mid-cycle");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("FAIL areset_ghost: got %0d stale results expected 0", seen); end
        do_op(16'd50, 8'd6, 4'd9, q, r, t, z, lat);
        vectors++;
        if (q !== 16'd8 || r !== 8'd2 || t !== 4'd9 || lat !== 16) begin
            miscompares++;
            $display("FAIL areset_post_op: got q=%0d r=%0d tag=%0d lat=%0d expected q=8 r=2 tag=9 lat=16", q, r, t, lat);
        end
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        logic [15:0] q; logic [7:0] r; logic [3:0] t; logic z; int lat;
        do_op(16'hFF9C, 8'd7, 4'd1, q, r, t, z, lat);
        vectors++;
        if (q !== 16'hFFF2 || r !== 8'hFE || z !== 1'b0) begin
            miscompares++;
            $display("FAIL signed_neg: got q=%h r=%h dbz=%b expected q=fff2 r=fe dbz=0", q, r, z);
        end
        do_op(16'h8000, 8'hFF, 4'd2, q, r, t, z, lat);
        vectors++;
        if (q !== 16'h8000 || r !== 8'h00 || z !== 1'b0) begin
            miscompares++;
            $display("FAIL signed_overflow: got q=%h r=%h dbz=%b expected q=8000 r=00 dbz=0", q, r, z);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_dbz();
        test_async_reset();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
